// File: rtl/wm_pkg.sv
// Shared types, default prices/durations and BCD conversion for the wash controller.
// Latency: n/a (types and combinational helpers). Backpressure: n/a.
// Prices and durations are kept in binary and converted to digits only when a wash is loaded.
package wm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WASH,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam int unsigned PRICE0_DEF = 10;
  localparam int unsigned PRICE1_DEF = 20;
  localparam int unsigned PRICE2_DEF = 30;
  localparam int unsigned PRICE3_DEF = 40;
  localparam int unsigned DUR0_DEF   = 30;
  localparam int unsigned DUR1_DEF   = 60;
  localparam int unsigned DUR2_DEF   = 90;
  localparam int unsigned DUR3_DEF   = 120;

  localparam logic [9:0] BAL_MAX = 10'd999;

  // Binary 0..999 to {hundreds, tens, ones}; larger inputs clamp to 999.
  function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
    logic [9:0] v;
    v = (bin > BAL_MAX) ? BAL_MAX : bin;
    return {4'(v / 10'd100), 4'((v / 10'd10) % 10'd10), 4'(v % 10'd10)};
  endfunction

endpackage

// File: rtl/wash_run_tick_gen.sv
// One-second tick generator: pulses tick on the cycle the counter wraps at TICK_DIV-1.
// Latency: tick is combinational from the counter. Backpressure: en=0 freezes the phase.
// The counter is never cleared except by rst, so a pause resumes mid-period.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/wash_run.sv
// Wash controller: funds check, price deduction, per-mode BCD countdown with pause.
// Latency: outputs registered with the state; handshake to first WASH cycle is 2 cycles.
// Backpressure: start_ready is high only in IDLE; start_valid elsewhere is dropped.
module wash_run
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned PRICE0   = PRICE0_DEF,
  parameter int unsigned PRICE1   = PRICE1_DEF,
  parameter int unsigned PRICE2   = PRICE2_DEF,
  parameter int unsigned PRICE3   = PRICE3_DEF,
  parameter int unsigned DUR0     = DUR0_DEF,
  parameter int unsigned DUR1     = DUR1_DEF,
  parameter int unsigned DUR2     = DUR2_DEF,
  parameter int unsigned DUR3     = DUR3_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [9:0] bal_in,
  input  logic [1:0] mode_in,
  input  logic       pause_pos,
  output logic [9:0] bal_out,
  output logic       err_funds,
  output logic       busy,
  output logic       done_pulse,
  output logic [3:0] t_h,
  output logic [3:0] t_t,
  output logic [3:0] t_o,
  output logic [2:0] state_led
);

  state_t     state, nxt;
  logic [9:0] bal_q;
  logic [1:0] mode_q;
  logic [9:0] price, dur;
  logic       funds_ok, hs, tick, wash_en;
  logic [3:0] dec_h, dec_t, dec_o;
  logic [2:0] led_nxt;

  assign hs       = start_valid & start_ready;
  assign funds_ok = bal_q >= price;
  assign wash_en  = (state == S_WASH);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (wash_en),
    .tick (tick)
  );

  always_comb begin
    price = 10'(PRICE0);
    dur   = 10'(DUR0);
    case (mode_q)
      2'd1: begin price = 10'(PRICE1); dur = 10'(DUR1); end
      2'd2: begin price = 10'(PRICE2); dur = 10'(DUR2); end
      2'd3: begin price = 10'(PRICE3); dur = 10'(DUR3); end
      default: ;
    endcase
  end

  // BCD minus one with borrow ripple; only used while the count is nonzero.
  always_comb begin
    dec_h = t_h;
    dec_t = t_t;
    dec_o = t_o - 4'd1;
    if (t_o == 4'd0) begin
      dec_o = 4'd9;
      dec_t = t_t - 4'd1;
      if (t_t == 4'd0) begin
        dec_t = 4'd9;
        dec_h = t_h - 4'd1;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (hs) nxt = S_CHECK;
      S_CHECK: nxt = funds_ok ? S_WASH : S_IDLE;
      S_WASH: begin
        // Last tick beats a simultaneous pause press.
        if (tick && {t_h, t_t, t_o} == 12'h001) nxt = S_DONE;
        else if (pause_pos)                     nxt = S_PAUSE;
      end
      S_PAUSE: if (pause_pos) nxt = S_WASH;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    led_nxt = 3'b001;
    case (nxt)
      S_WASH:  led_nxt = 3'b010;
      S_PAUSE: led_nxt = 3'b100;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bal_q       <= '0;
      mode_q      <= '0;
      bal_out     <= '0;
      t_h         <= '0;
      t_t         <= '0;
      t_o         <= '0;
      err_funds   <= 1'b0;
      done_pulse  <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
      state_led   <= 3'b001;
    end else begin
      state       <= nxt;
      start_ready <= (nxt == S_IDLE);
      busy        <= (nxt == S_WASH) || (nxt == S_PAUSE);
      state_led   <= led_nxt;
      done_pulse  <= (nxt == S_DONE);
      err_funds   <= (state == S_CHECK) && !funds_ok;
      if (hs) begin
        bal_q  <= (bal_in > BAL_MAX) ? BAL_MAX : bal_in;
        mode_q <= mode_in;
      end
      if (state == S_CHECK) begin
        bal_out <= funds_ok ? bal_q - price : bal_q;
        if (funds_ok) {t_h, t_t, t_o} <= bin2bcd(dur);
      end else if (wash_en && tick) begin
        {t_h, t_t, t_o} <= {dec_h, dec_t, dec_o};
      end
    end
  end

endmodule
